// File: rtl/card_regfile.sv
// Per-card word store: snapshots all words on a vblank rise and streams them down the sync chain.
// rd_data has 1-cycle latency with write-through; the chain has no backpressure, and a missing done return times out.
module card_regfile #(
   parameter int          NUM_CARDS  = 12,
   parameter logic [13:0] RESET_WORD = 14'h0000,
   parameter int          TIMEOUT    = 32
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vblank,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [13:0] wr_data,
   input  logic [3:0]  rd_addr,
   output logic [13:0] rd_data,
   output logic        regfile_sync,
   output logic [13:0] regfile_out,
   input  logic        regfile_sync_done,
   output logic        busy,
   output logic        sync_err,
   output logic [7:0]  update_cnt
);
   localparam int IW = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

   state_t        state;
   logic [13:0]   live [NUM_CARDS];
   logic [13:0]   snap [NUM_CARDS];
   logic [IW-1:0] idx;
   logic [5:0]    tcnt;
   logic          vb_q;
   logic          vb_rise;
   logic          wr_hit;
   logic          rd_hit;
   logic          tmo;

   assign vb_rise     = vblank & ~vb_q;
   assign wr_hit      = wr_en && (int'(wr_addr) < NUM_CARDS);
   assign rd_hit      = int'(rd_addr) < NUM_CARDS;
   assign tmo         = int'(tcnt) == TIMEOUT - 1;
   assign busy        = (state != IDLE);
   assign regfile_out = (state == STREAM) ? snap[idx] : '0;

   always_ff @(posedge pclk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CARDS; i++) live[i] <= RESET_WORD;
         rd_data <= '0;
         vb_q    <= 1'b1;
      end else begin
         vb_q <= vblank;
         if (wr_hit) live[wr_addr[IW-1:0]] <= wr_data;
         // forward a same-cycle write so readback sees it one cycle later
         if (wr_hit && (wr_addr == rd_addr)) rd_data <= wr_data;
         else if (rd_hit)                    rd_data <= live[rd_addr[IW-1:0]];
         else                                rd_data <= '0;
      end
   end

   always_ff @(posedge pclk) begin
      if (!rst) begin
         state        <= IDLE;
         idx          <= '0;
         tcnt         <= '0;
         regfile_sync <= 1'b0;
         sync_err     <= 1'b0;
         update_cnt   <= '0;
         for (int i = 0; i < NUM_CARDS; i++) snap[i] <= RESET_WORD;
      end else begin
         regfile_sync <= 1'b0;
         if ((state != IDLE) && (tcnt != 6'h3f)) tcnt <= tcnt + 6'd1;
         case (state)
            IDLE: begin
               // snapshot takes pre-write values; a same-cycle write lands next frame
               if (vb_rise) begin
                  for (int i = 0; i < NUM_CARDS; i++) snap[i] <= live[i];
                  idx          <= '0;
                  tcnt         <= '0;
                  regfile_sync <= 1'b1;
                  state        <= STREAM;
               end
            end
            STREAM: begin
               idx <= idx + 1'b1;
               if (tmo) begin
                  sync_err <= 1'b1;
                  state    <= IDLE;
               end else if (int'(idx) == NUM_CARDS - 1) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (regfile_sync_done) begin
                  update_cnt <= update_cnt + 8'd1;
                  state      <= IDLE;
               end else if (tmo) begin
                  sync_err <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_card_regfile.sv
// Bench for card_regfile: register read/write vectors plus full-frame stream checks against a chain model.
module tb_card_regfile;
   localparam int N   = 12;
   localparam int TMO = 32;

   logic        pclk    = 1'b0;
   logic        rst     = 1'b0;
   logic        vblank  = 1'b1;
   logic        wr_en   = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [13:0] wr_data = '0;
   logic [3:0]  rd_addr = '0;
   logic [13:0] rd_data;
   logic        regfile_sync;
   logic [13:0] regfile_out;
   logic        regfile_sync_done;
   logic        busy;
   logic        sync_err;
   logic [7:0]  update_cnt;

   card_regfile #(.NUM_CARDS(N), .RESET_WORD(14'h0000), .TIMEOUT(TMO)) dut (
      .pclk(pclk), .rst(rst), .vblank(vblank), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .regfile_sync(regfile_sync),
      .regfile_out(regfile_out), .regfile_sync_done(regfile_sync_done), .busy(busy),
      .sync_err(sync_err), .update_cnt(update_cnt)
   );

   always #5 pclk = ~pclk;

   // chain model: each card delays the pulse by one pclk
   logic [N-1:0] chain   = '0;
   logic         done_en = 1'b1;
   always @(posedge pclk) chain <= {chain[N-2:0], regfile_sync};
   assign regfile_sync_done = done_en & chain[N-1];

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [13:0] wd;
      logic [3:0]  ra;
      logic [13:0] exp;
   } vec_t;

   vec_t        tbl [10];
   int          n_chk    = 0;
   int          n_fail   = 0;
   int          n_pulse  = 0;
   int          cap_left = 0;
   logic [13:0] exp_q [$];
   logic [13:0] m_live [N];
   logic [7:0]  m_cnt = '0;
   logic        m_err = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // advance one cycle, then score the stream bus for that cycle
   task automatic tick();
      @(negedge pclk);
      if (regfile_sync === 1'b1) begin
         n_pulse++;
         cap_left = N;
      end
      if (cap_left > 0) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL stream_word: got 0x%0h, expected no word at %0t", regfile_out, $time);
         end else begin
            chk("stream_word", regfile_out, exp_q.pop_front());
         end
         cap_left--;
      end else begin
         chk("out_idle_zero", regfile_out, 0);
      end
   endtask

   task automatic frame(input bit do_wr, input logic [3:0] wa, input logic [13:0] wd,
                        input bit toggle, input bit done_ok);
      int p0 = n_pulse;
      for (int i = 0; i < N; i++) exp_q.push_back(m_live[i]);
      vblank = 1'b1;
      if (do_wr) begin
         wr_en   = 1'b1;
         wr_addr = wa;
         wr_data = wd;
         rd_addr = wa;
         if (wa < N) m_live[wa] = wd;
      end
      tick();
      wr_en = 1'b0;
      chk("sync_first", regfile_sync, 1);
      chk("busy_first", busy, 1);
      if (do_wr) chk("rd_after_wr", rd_data, (wa < N) ? wd : 14'h0);
      for (int k = 2; k <= (done_ok ? N + 1 : TMO); k++) begin
         if (toggle && k == 4) vblank = 1'b0;
         if (toggle && k == 6) vblank = 1'b1;
         tick();
         chk("sync_once", regfile_sync, 0);
         chk("busy_hold", busy, 1);
         chk("err_hold", sync_err, m_err);
      end
      tick();
      if (done_ok) m_cnt++;
      else         m_err = 1'b1;
      chk("busy_end", busy, 0);
      chk("update_cnt", update_cnt, m_cnt);
      chk("sync_err", sync_err, m_err);
      vblank = 1'b0;
      repeat (4) tick();
      chk("stream_len", exp_q.size(), 0);
      chk("pulse_count", n_pulse, p0 + 1);
   endtask

   initial begin
      int p_rs;
      tbl[0] = '{1'b0, 4'd0,  14'h0000, 4'd0,  14'h0000};
      tbl[1] = '{1'b1, 4'd13, 14'h1234, 4'd13, 14'h0000};
      tbl[2] = '{1'b0, 4'd0,  14'h0000, 4'd13, 14'h0000};
      tbl[3] = '{1'b1, 4'd3,  14'h2aaa, 4'd3,  14'h2aaa};
      tbl[4] = '{1'b0, 4'd0,  14'h0000, 4'd3,  14'h2aaa};
      tbl[5] = '{1'b1, 4'd12, 14'h1111, 4'd12, 14'h0000};
      tbl[6] = '{1'b1, 4'd11, 14'h3fff, 4'd11, 14'h3fff};
      tbl[7] = '{1'b0, 4'd0,  14'h0000, 4'd15, 14'h0000};
      tbl[8] = '{1'b1, 4'd0,  14'h0155, 4'd11, 14'h3fff};
      tbl[9] = '{1'b0, 4'd0,  14'h0000, 4'd0,  14'h0155};
      for (int i = 0; i < N; i++) m_live[i] = 14'h0000;

      // reset with vblank held high through release
      repeat (3) tick();
      chk("rst_rd", rd_data, 0);
      chk("rst_sync", regfile_sync, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", sync_err, 0);
      chk("rst_cnt", update_cnt, 0);
      rst = 1'b1;
      repeat (5) tick();
      chk("vblank_at_release", n_pulse, 0);
      chk("busy_at_release", busy, 0);
      vblank = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         wr_en   = tbl[i].we;
         wr_addr = tbl[i].wa;
         wr_data = tbl[i].wd;
         rd_addr = tbl[i].ra;
         tick();
         wr_en = 1'b0;
         if (tbl[i].we && tbl[i].wa < N) m_live[tbl[i].wa] = tbl[i].wd;
         chk("table_rd", rd_data, tbl[i].exp);
      end

      for (int i = 0; i < N; i++) begin
         wr_en   = 1'b1;
         wr_addr = 4'(i);
         wr_data = 14'h100 + 14'(i);
         rd_addr = 4'(i);
         tick();
         m_live[i] = 14'h100 + 14'(i);
         chk("wr_fill", rd_data, m_live[i]);
      end
      wr_en = 1'b0;

      frame(1'b0, 4'd0, 14'h0, 1'b0, 1'b1);
      frame(1'b1, 4'd5, 14'h3fff, 1'b0, 1'b1);
      frame(1'b0, 4'd0, 14'h0, 1'b1, 1'b1);

      done_en = 1'b0;
      frame(1'b0, 4'd0, 14'h0, 1'b0, 1'b0);
      done_en = 1'b1;
      frame(1'b0, 4'd0, 14'h0, 1'b0, 1'b1);

      // reset while word 6 is on the bus
      for (int i = 0; i < N; i++) exp_q.push_back(m_live[i]);
      vblank = 1'b1;
      tick();
      for (int k = 1; k <= 6; k++) tick();
      p_rs = n_pulse;
      rst = 1'b0;
      cap_left = 0;
      exp_q.delete();
      tick();
      chk("rs_sync", regfile_sync, 0);
      chk("rs_rd", rd_data, 0);
      chk("rs_busy", busy, 0);
      chk("rs_err", sync_err, 0);
      chk("rs_cnt", update_cnt, 0);
      m_cnt = '0;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) m_live[i] = 14'h0000;
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         rd_addr = 4'(i);
         tick();
         chk("rs_live", rd_data, m_live[i]);
      end
      chk("rs_no_pulse", n_pulse, p_rs);
      chk("rs_cnt_hold", update_cnt, m_cnt);
      vblank = 1'b0;
      tick();
      frame(1'b0, 4'd0, 14'h0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
